// File: rtl/hazard_ctrl.sv
// Hazard control for a five-stage pipeline with a multi-cycle multiply/divide
// unit. It detects RAW hazards on the D-stage sources from the Tuse/Tnew
// timing, tracks multiply/divide occupancy and requests a pipeline stall.
// It also counts stall cycles, saturating at the all-ones value.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic [1:0]  E_md_start,
  input  logic        D_md_use,
  output logic        stall,
  output logic        PC_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_op_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);
  localparam logic [1:0] TUSE_NONE = 2'd3;

  logic [3:0] md_cnt;
  logic       md_start_valid;
  logic [3:0] md_load;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;

  // A source stalls when a pending producer in E or M will deliver its value
  // later than the instruction in D needs it. Register 0 never creates a
  // dependency, and a Tuse of 3 marks the operand as unused.
  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] e_a3,
                                      input logic [1:0] e_tnew,
                                      input logic [4:0] m_a3,
                                      input logic [1:0] m_tnew);
    logic e_hit;
    logic m_hit;
    e_hit = (src == e_a3) && (e_tnew > tuse);
    m_hit = (src == m_a3) && (m_tnew > tuse);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
  endfunction

  // Decode a start request; a start is accepted only when the unit is idle,
  // and the reserved encoding is treated as no operation.
  always_comb begin
    md_start_valid = 1'b0;
    md_load        = 4'd0;
    if (md_cnt == 4'd0) begin
      unique case (md_op_e'(E_md_start))
        MD_MULT: begin
          md_start_valid = 1'b1;
          md_load        = MULT_LOAD;
        end
        MD_DIV: begin
          md_start_valid = 1'b1;
          md_load        = DIV_LOAD;
        end
        MD_NONE, MD_RSVD: begin
          md_start_valid = 1'b0;
          md_load        = 4'd0;
        end
      endcase
    end
  end

  // Combine the data hazards and the multiply/divide structural hazard into
  // the stall request and the pipeline enables, all in the same cycle.
  always_comb begin
    stall_rs = src_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
    stall_rt = src_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
    md_busy  = (md_cnt != 4'd0) || md_start_valid;
    stall_md = D_md_use && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
    PC_en    = ~stall;
    D_en     = ~stall;
    E_clr    = stall;
  end

  // Multiply/divide occupancy counter: load on an accepted start, then count
  // down to zero and hold there.
  // NOTE: all state is cleared by the asynchronous reset and updated with
  // non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= 4'd0;
    end else if (md_start_valid) begin
      md_cnt <= md_load;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  // Stall-cycle counter, saturating instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
